// File: rtl/retire_trace_tx.sv
// Retirement-trace transmitter: captures WB register writes into a FIFO and
// streams each record as a 5-beat, 32-bit valid/ready packet.
module retire_trace_tx #(
    parameter int          DEPTH   = 8,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     wb_reg_write,
    input  logic [4:0]               wb_rd,
    input  logic [63:0]              wb_pc,
    input  logic [63:0]              wb_write_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [31:0]              tx_data,
    output logic                     tx_last,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [11:0] seq;
        logic        ovf;
    } rec_t;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    rec_t          mem_q [DEPTH];
    rec_t          head;
    rec_t          wr_rec;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [11:0]   seq_q, seq_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    state_t        state_q, state_d;
    logic [2:0]    beat_q, beat_d;

    logic          cap;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // A full FIFO still accepts a record when the head retires in the same cycle.
    always_comb begin
        cap  = trace_en & wb_reg_write & (wb_rd != 5'd0);
        full = (count_q == LW'(DEPTH));
        pop  = (state_q == S_SEND) && (beat_q == 3'd4) && tx_ready;
        push = cap && (!full || pop);
        drop = cap && !push;
    end

    always_comb begin
        wr_rec      = '0;
        wr_rec.pc   = wb_pc;
        wr_rec.data = wb_write_data;
        wr_rec.rd   = wb_rd;
        wr_rec.seq  = seq_q;
        wr_rec.ovf  = ovf_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            seq_d    = seq_q + 12'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end

        // The overflow marker rides on the next accepted record, then clears.
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (push) begin
            ovf_d = 1'b0;
        end
    end

    // Looking at count_d lets a push into an empty FIFO start beat0 next cycle.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (count_d != '0) begin
                    state_d = S_SEND;
                    beat_d  = 3'd0;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (beat_q == 3'd4) begin
                        beat_d = 3'd0;
                        if (count_d == '0) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        tx_valid = (state_q == S_SEND);
        tx_last  = (state_q == S_SEND) && (beat_q == 3'd4);
        tx_data  = 32'd0;
        if (state_q == S_SEND) begin
            case (beat_q)
                3'd0:    tx_data = {HDR_TAG, 2'b00, head.ovf, 1'b1, head.rd, 3'b000, head.seq};
                3'd1:    tx_data = head.pc[31:0];
                3'd2:    tx_data = head.pc[63:32];
                3'd3:    tx_data = head.data[31:0];
                3'd4:    tx_data = head.data[63:32];
                default: tx_data = 32'd0;
            endcase
        end
        drop_count = drop_q;
        fifo_level = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= 12'd0;
            ovf_q    <= 1'b0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Record storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx (DEPTH=4): packet format, stalls, overflow,
// full-FIFO push/pop, capture gating, seq wrap and mid-packet reset.
module tb_retire_trace_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_pc;
    logic [63:0] wb_write_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_last;
    logic [15:0] drop_count;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    retire_trace_tx #(.DEPTH(4), .HDR_TAG(8'hA5)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_pc(wb_pc), .wb_write_data(wb_write_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] b0(input logic ovf, input logic [4:0] rd, input logic [11:0] seq);
        return {8'hA5, 2'b00, ovf, 1'b1, rd, 3'b000, seq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap_on(input logic [4:0] rd, input logic [63:0] pc, input logic [63:0] data);
        trace_en      = 1'b1;
        wb_reg_write  = 1'b1;
        wb_rd         = rd;
        wb_pc         = pc;
        wb_write_data = data;
    endtask

    task automatic cap_off();
        wb_reg_write  = 1'b0;
        wb_rd         = 5'd0;
        wb_pc         = 64'd0;
        wb_write_data = 64'd0;
    endtask

    task automatic do_reset();
        cap_off();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trace_en = 1'b1; tx_ready = 1'b1; cap_off();
        tick(); tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", tx_valid); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", tx_data); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", tx_last); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
        rst = 1'b0;
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", tx_valid); end
    endtask

    task automatic test_single_packet();
        logic [31:0] ex [5];
        ex[0] = b0(1'b0, 5'd3, 12'd0); ex[1] = 32'h40; ex[2] = 32'h0; ex[3] = 32'd34; ex[4] = 32'h0;
        tx_ready = 1'b1;
        cap_on(5'd3, 64'h40, 64'd34);
        tick();
        cap_off();
        for (int b = 0; b < 5; b++) begin
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat%0d got %b exp 1", b, tx_valid); end
            checks++; if (tx_data !== ex[b]) begin errors++; $display("FAIL single_data beat%0d got %h exp %h", b, tx_data, ex[b]); end
            checks++; if (tx_last !== (b == 4)) begin errors++; $display("FAIL single_last beat%0d got %b exp %b", b, tx_last, (b == 4)); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b exp 0", tx_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_end_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_stall();
        logic [31:0] ex [5];
        logic [9:0]  pat;
        int          idx;
        pat = 10'b1001101001;
        ex[0] = b0(1'b0, 5'd3, 12'd1); ex[1] = 32'h40; ex[2] = 32'h0; ex[3] = 32'd34; ex[4] = 32'h0;
        idx = 0;
        cap_on(5'd3, 64'h40, 64'd34);
        tick();
        cap_off();
        for (int k = 0; k < 10 && idx < 5; k++) begin
            tx_ready = pat[k];
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_valid k%0d got %b exp 1", k, tx_valid); end
            checks++; if (tx_data !== ex[idx]) begin errors++; $display("FAIL stall_data k%0d got %h exp %h", k, tx_data, ex[idx]); end
            checks++; if (tx_last !== (idx == 4)) begin errors++; $display("FAIL stall_last k%0d got %b exp %b", k, tx_last, (idx == 4)); end
            checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL stall_level k%0d got %0d exp 1", k, fifo_level); end
            tick();
            if (pat[k]) idx++;
        end
        tx_ready = 1'b1;
        checks++; if (idx != 5) begin errors++; $display("FAIL stall_beats got %0d exp 5", idx); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %b exp 0", tx_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL stall_end_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cap_on(5'(i + 1), 64'h100 + 64'(i * 4), 64'(i));
            tick();
        end
        cap_off();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_count); end
        checks++; if (tx_data !== b0(1'b0, 5'd1, 12'd0)) begin errors++; $display("FAIL ovf_head got %h exp %h", tx_data, b0(1'b0, 5'd1, 12'd0)); end
        tx_ready = 1'b1;
        repeat (5) tick();
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL ovf_drain_level got %0d exp 3", fifo_level); end
        checks++; if (tx_data !== b0(1'b0, 5'd2, 12'd1)) begin errors++; $display("FAIL ovf_next_head got %h exp %h", tx_data, b0(1'b0, 5'd2, 12'd1)); end
        tx_ready = 1'b0;
        cap_on(5'd7, 64'h200, 64'hDEAD);
        tick();
        cap_off();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_refill_level got %0d exp 4", fifo_level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_refill_drop got %0d exp 2", drop_count); end
        tx_ready = 1'b1;
        repeat (15) tick();
        checks++; if (tx_data !== b0(1'b1, 5'd7, 12'd4)) begin errors++; $display("FAIL ovf_flag_beat0 got %h exp %h", tx_data, b0(1'b1, 5'd7, 12'd4)); end
        tick();
        checks++; if (tx_data !== 32'h200) begin errors++; $display("FAIL ovf_flag_pc got %h exp 200", tx_data); end
        repeat (2) tick();
        checks++; if (tx_data !== 32'hDEAD) begin errors++; $display("FAIL ovf_flag_data got %h exp dead", tx_data); end
        repeat (2) tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_end_valid got %b exp 0", tx_valid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cap_on(5'(i + 1), 64'h300 + 64'(i), 64'(i));
            tick();
        end
        cap_off();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", fifo_level); end
        tx_ready = 1'b1;
        repeat (4) tick();
        checks++; if (tx_last !== 1'b1) begin errors++; $display("FAIL full_last got %b exp 1", tx_last); end
        cap_on(5'd9, 64'h900, 64'h99);
        tick();
        cap_off();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_pp_level got %0d exp 4", fifo_level); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL full_pp_drop got %0d exp 0", drop_count); end
        checks++; if (tx_data !== b0(1'b0, 5'd2, 12'd1)) begin errors++; $display("FAIL full_pp_head got %h exp %h", tx_data, b0(1'b0, 5'd2, 12'd1)); end
        repeat (15) tick();
        checks++; if (tx_data !== b0(1'b0, 5'd9, 12'd4)) begin errors++; $display("FAIL full_pp_rec got %h exp %h", tx_data, b0(1'b0, 5'd9, 12'd4)); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL full_pp_last_level got %0d exp 1", fifo_level); end
        repeat (5) tick();
    endtask

    task automatic test_gating_and_wrap();
        logic [4:0] rd;
        do_reset();
        tx_ready = 1'b1;
        trace_en = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_pc = 64'h10; wb_write_data = 64'h1;
        tick();
        trace_en = 1'b1; wb_rd = 5'd0;
        tick();
        cap_off();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL gate_valid got %b exp 0", tx_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL gate_level got %0d exp 0", fifo_level); end
        cap_on(5'd4, 64'h44, 64'h4);
        tick();
        cap_off();
        checks++; if (tx_data !== b0(1'b0, 5'd4, 12'd0)) begin errors++; $display("FAIL gate_seq got %h exp %h", tx_data, b0(1'b0, 5'd4, 12'd0)); end
        repeat (5) tick();
        for (int i = 1; i < 4096; i++) begin
            rd = 5'((i % 31) + 1);
            cap_on(rd, 64'(i), 64'(i));
            tick();
            cap_off();
            if (i == 4095) begin
                checks++; if (tx_data !== b0(1'b0, rd, 12'hFFF)) begin errors++; $display("FAIL wrap_fff got %h exp %h", tx_data, b0(1'b0, rd, 12'hFFF)); end
            end
            repeat (5) tick();
        end
        cap_on(5'd6, 64'h66, 64'h6);
        tick();
        cap_off();
        checks++; if (tx_data !== b0(1'b0, 5'd6, 12'h000)) begin errors++; $display("FAIL wrap_000 got %h exp %h", tx_data, b0(1'b0, 5'd6, 12'h000)); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL wrap_drop got %0d exp 0", drop_count); end
        repeat (5) tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cap_on(5'(i + 10), 64'h500 + 64'(i), 64'(i));
            tick();
        end
        cap_off();
        tx_ready = 1'b1;
        repeat (3) tick();
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL mid_pre_beat3 got %h exp 0", tx_data); end
        rst = 1'b1;
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", tx_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
        checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL mid_data got %h exp 0", tx_data); end
        rst = 1'b0;
        cap_on(5'd2, 64'h80, 64'd5);
        tick();
        cap_off();
        checks++; if (tx_data !== b0(1'b0, 5'd2, 12'd0)) begin errors++; $display("FAIL mid_new_beat0 got %h exp %h", tx_data, b0(1'b0, 5'd2, 12'd0)); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL mid_new_level got %0d exp 1", fifo_level); end
        repeat (5) tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_end_valid got %b exp 0", tx_valid); end
    endtask

    initial begin
        rst = 1'b1; trace_en = 1'b0; tx_ready = 1'b0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_pc = 64'd0; wb_write_data = 64'd0;
        test_reset();
        test_single_packet();
        test_stall();
        test_overflow();
        test_full_push_pop();
        test_gating_and_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
